// File: rtl/gate_sweep_pkg.sv
// Shared opcode and FSM state types for the gate sweep unit.
package gate_sweep_pkg;

  typedef enum logic [2:0] {
    OP_NOT  = 3'd0,
    OP_AND  = 3'd1,
    OP_OR   = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/gate_op_unit.sv
// Combinational bitwise gate evaluation for one operand pair.
module gate_op_unit
  import gate_sweep_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_NOT:  y = ~a;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/gate_sweep_unit.sv
// Exhaustive operand sweep through a selectable bitwise gate.
// Define GATE_SWEEP_SIG_EN to build the rotate-XOR result signature on sig.
module gate_sweep_unit
  import gate_sweep_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] y_out,
  output logic             y_valid,
  output logic [WIDTH-1:0] sig
);

  state_e               state_reg;
  op_e                  op_reg;
  logic [2*WIDTH-1:0]   count_reg;
  logic                 busy_reg;
  logic                 done_reg;
  logic                 y_valid_reg;
  logic [WIDTH-1:0]     y_reg;
  logic [WIDTH-1:0]     gate_y;

  // The applied operands are simply the two halves of the sweep counter.
  assign a_out   = count_reg[2*WIDTH-1:WIDTH];
  assign b_out   = count_reg[WIDTH-1:0];
  assign busy    = busy_reg;
  assign done    = done_reg;
  assign y_valid = y_valid_reg;
  assign y_out   = y_reg;

  gate_op_unit #(.WIDTH(WIDTH)) u_gate (
    .a  (a_out),
    .b  (b_out),
    .op (op_reg),
    .y  (gate_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      op_reg      <= OP_NOT;
      count_reg   <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      y_valid_reg <= 1'b0;
      y_reg       <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          done_reg    <= 1'b0;
          y_valid_reg <= 1'b0;
          if (start) begin
            op_reg    <= op_e'(op);
            count_reg <= '0;
            busy_reg  <= 1'b1;
            state_reg <= ST_RUN;
          end
        end
        ST_RUN: begin
          y_reg       <= gate_y;
          y_valid_reg <= 1'b1;
          // Stop on the last combination so the operands stay put through drain.
          if (count_reg == '1) begin
            state_reg <= ST_DRAIN;
          end else begin
            count_reg <= count_reg + 1'b1;
          end
        end
        ST_DRAIN: begin
          y_valid_reg <= 1'b0;
          busy_reg    <= 1'b0;
          done_reg    <= 1'b1;
          state_reg   <= ST_DONE;
        end
        ST_DONE: begin
          done_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

`ifdef GATE_SWEEP_SIG_EN
  logic [WIDTH-1:0] sig_reg;
  logic [WIDTH-1:0] sig_rot;

  generate
    if (WIDTH == 1) begin : g_sig_w1
      assign sig_rot = sig_reg;
    end else begin : g_sig_wn
      assign sig_rot = {sig_reg[WIDTH-2:0], sig_reg[WIDTH-1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_reg <= '0;
    end else if (state_reg == ST_IDLE && start) begin
      sig_reg <= '0;
    end else if (y_valid_reg) begin
      sig_reg <= sig_rot ^ y_reg;
    end
  end

  assign sig = sig_reg;
`else
  assign sig = '0;
`endif

endmodule

// File: tb/tb_gate_sweep_unit.sv
// Scoreboard bench for gate_sweep_unit at WIDTH=1 and WIDTH=2.
module tb_gate_sweep_unit;

`ifdef GATE_SWEEP_SIG_EN
  localparam bit SIG_EN = 1'b1;
`else
  localparam bit SIG_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] op;
  logic       sel2;

  logic       start1, start2;
  logic       busy1, done1, yv1, busy2, done2, yv2;
  logic [0:0] a1, b1, y1, sig1;
  logic [1:0] a2, b2, y2, sig2;

  logic       m_busy, m_done, m_yv;
  logic [7:0] m_a, m_b, m_y, m_sig;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  assign start1 = start & ~sel2;
  assign start2 = start & sel2;
  assign m_busy = sel2 ? busy2 : busy1;
  assign m_done = sel2 ? done2 : done1;
  assign m_yv   = sel2 ? yv2 : yv1;
  assign m_a    = sel2 ? {6'd0, a2} : {7'd0, a1};
  assign m_b    = sel2 ? {6'd0, b2} : {7'd0, b1};
  assign m_y    = sel2 ? {6'd0, y2} : {7'd0, y1};
  assign m_sig  = sel2 ? {6'd0, sig2} : {7'd0, sig1};

  gate_sweep_unit #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .op(op), .busy(busy1), .done(done1),
    .a_out(a1), .b_out(b1), .y_out(y1), .y_valid(yv1), .sig(sig1)
  );

  gate_sweep_unit #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .op(op), .busy(busy2), .done(done2),
    .a_out(a2), .b_out(b2), .y_out(y2), .y_valid(yv2), .sig(sig2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] gate_model(input logic [2:0] o, input logic [7:0] a,
                                            input logic [7:0] b, input int w);
    logic [7:0] mask;
    logic [7:0] r;
    mask = 8'((1 << w) - 1);
    case (o)
      3'd0: r = ~a;
      3'd1: r = a & b;
      3'd2: r = a | b;
      3'd3: r = ~(a & b);
      3'd4: r = ~(a | b);
      3'd5: r = a ^ b;
      3'd6: r = ~(a ^ b);
      default: r = 8'd0;
    endcase
    return r & mask;
  endfunction

  function automatic logic [7:0] sig_step(input logic [7:0] s, input logic [7:0] y, input int w);
    logic [7:0] mask;
    logic [7:0] rot;
    mask = 8'((1 << w) - 1);
    if (w == 1) rot = s;
    else rot = ((s << 1) | (s >> (w - 1))) & mask;
    return rot ^ y;
  endfunction

  // Start a sweep and fill the scoreboard; returns the expected signature and final y.
  task automatic launch(input int w, input logic [2:0] o, output logic [7:0] esig,
                        output logic [7:0] last_y);
    int n;
    logic [7:0] e;
    n = 1 << (2 * w);
    esig = 8'd0;
    last_y = 8'd0;
    exp_q.delete();
    for (int c = 0; c < n; c++) begin
      e = gate_model(o, 8'(c >> w), 8'(c & ((1 << w) - 1)), w);
      exp_q.push_back(e);
      esig = sig_step(esig, e, w);
      last_y = e;
    end
    if (!SIG_EN) esig = 8'd0;
    @(negedge clk);
    sel2 = (w == 2);
    op = o;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_cycle(input int w, input int cyc);
    int n;
    int ab;
    logic [7:0] e;
    n = 1 << (2 * w);
    ab = (cyc <= n) ? cyc - 1 : n - 1;
    check("busy", m_busy, (cyc >= 1 && cyc <= n + 1));
    check("done", m_done, (cyc == n + 2));
    check("y_valid", m_yv, (cyc >= 2 && cyc <= n + 1));
    check("a_out", m_a, 8'(ab >> w));
    check("b_out", m_b, 8'(ab & ((1 << w) - 1)));
    if (m_yv) begin
      if (exp_q.size() == 0) check("extra_valid", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("y_out", m_y, e);
        $display("w=%0d cyc=%0d a=%0h b=%0h y=%0h", w, cyc, m_a, m_b, m_y);
      end
    end
  endtask

  task automatic sweep(input int w, input logic [2:0] o, input bit restart_mid);
    int n;
    logic [7:0] esig, last_y;
    n = 1 << (2 * w);
    launch(w, o, esig, last_y);
    for (int cyc = 1; cyc <= n + 3; cyc++) begin
      if (cyc > 1) @(negedge clk);
      check_cycle(w, cyc);
      if (restart_mid && cyc == 3) begin
        start = 1'b1;
        op = ~o;
      end else begin
        start = 1'b0;
      end
    end
    check("queue_empty", exp_q.size(), 0);
    check("sig", m_sig, esig);
    check("y_hold", m_y, last_y);
    $display("sweep w=%0d op=%0d sig=%0h done", w, o, m_sig);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    op = 3'd0;
    sel2 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out1", {busy1, done1, yv1, a1, b1, y1, sig1}, 0);
    check("rst_out2", {busy2, done2, yv2, a2, b2, y2, sig2}, 0);
    rst = 1'b0;

    sweep(1, 3'd1, 1'b0);   // AND
    sweep(1, 3'd5, 1'b0);   // XOR
    sweep(1, 3'd6, 1'b0);   // XNOR
    sweep(2, 3'd0, 1'b0);   // NOT
    sweep(2, 3'd7, 1'b1);   // reserved, with ignored restart
    sweep(2, 3'd3, 1'b0);   // NAND

    // Reset in the middle of an OR sweep.
    begin
      logic [7:0] esig, last_y;
      launch(2, 3'd2, esig, last_y);
      for (int cyc = 1; cyc <= 5; cyc++) begin
        if (cyc > 1) @(negedge clk);
        check_cycle(2, cyc);
      end
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_out", {m_busy, m_done, m_yv, m_a, m_b, m_y, m_sig}, 0);
      rst = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check("post_rst_idle", {m_busy, m_done, m_yv}, 0);
      end
      $display("mid-sweep reset handled");
    end
    sweep(2, 3'd2, 1'b0);   // OR, fresh start after reset
    sweep(1, 3'd1, 1'b0);   // AND again

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gate_sweep_unit.md
GATE_SWEEP_UNIT -- requirements
Module: gate_sweep_unit

Interface
REQ-001 The parameter list SHALL be: WIDTH, default 1, operand width in bits; legal range 1..8.
REQ-002 The port list SHALL be: clk  input  1  single clock; all logic on rising edge.
REQ-003 The port list SHALL continue: rst  input  1  reset, synchronous and active-high.
REQ-004 The port list SHALL continue: start  input  1  request an exhaustive operand sweep.
REQ-005 The port list SHALL continue: op  input  3  gate select, sampled with start.
REQ-006 The port list SHALL continue: busy  output  1  sweep in progress.
REQ-007 The port list SHALL continue: done  output  1  one-cycle completion pulse.
REQ-008 The port list SHALL continue: a_out, b_out  output  WIDTH each  currently applied operands.
REQ-009 The port list SHALL continue: y_out  output  WIDTH  registered gate result.
REQ-010 The port list SHALL continue: y_valid  output  1  y_out holds the result of a swept combination.
REQ-011 The port list SHALL end with: sig  output  WIDTH  result signature (see Configuration).

Function
REQ-012 Opcodes SHALL be bitwise: 0 NOT a, 1 AND, 2 OR, 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 reserved -> all zeros.
REQ-013 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-014 IDLE with start=1 SHALL do all of the following on that edge: latch op, clear the 2*WIDTH-bit counter, load a_out=b_out=0, and move to RUN.
REQ-015 In RUN, each edge SHALL increment the counter, with a_out = counter[2W-1:W] and b_out = counter[W-1:0].
REQ-016 When the counter reaches the all-ones combination, the next edge SHALL move the FSM to DRAIN and hold a_out/b_out; the counter SHALL NOT wrap.
REQ-017 y_out SHALL equal op applied to the a_out/b_out of the previous cycle; y_valid=1 in every cycle following a RUN cycle (one-cycle latency).
REQ-018 DRAIN SHALL last exactly one cycle, carry the final y_valid, and move to DONE.
REQ-019 DONE SHALL last exactly one cycle with done=1, then move to IDLE; y_valid=0 in DONE.
REQ-020 busy SHALL be 1 in RUN and DRAIN, and 0 otherwise.
REQ-021 With start sampled at edge 0, done SHALL be high in cycle 2^(2*WIDTH)+2; exactly 2^(2*WIDTH) y_valid cycles SHALL occur.
REQ-022 start SHALL be ignored outside IDLE; a change of op during a sweep SHALL have no effect.
REQ-023 a_out, b_out and y_out SHALL hold their last values in IDLE.

Reset
REQ-024 rst=1 SHALL force IDLE from any state, including mid-sweep, with no done pulse.
REQ-025 rst=1 SHALL clear busy, done, y_valid, a_out, b_out, y_out, sig, counter and latched op to 0.
REQ-026 rst SHALL take priority over start in the same cycle.

Configuration
REQ-027 With GATE_SWEEP_SIG_EN defined, sig SHALL be cleared on an accepted start and, on each y_valid cycle, become {sig[W-2:0], sig[W-1]} XOR y_out (pure XOR accumulate when WIDTH=1).
REQ-028 With GATE_SWEEP_SIG_EN defined, sig SHALL hold its value in IDLE/DONE.
REQ-029 Without GATE_SWEEP_SIG_EN, the sig port SHALL remain present, be tied to 0, and have no signature register synthesised.

Structure
REQ-030 A shared package gate_sweep_pkg SHALL hold the opcode enum (OP_NOT..OP_RSVD) and the FSM state typedef.
REQ-031 The combinational gate evaluation SHALL be one sub-module, gate_op_unit (WIDTH parameter; a, b, op in; y out), instantiated once.

Verification
REQ-032 WIDTH=1, op=AND, start pulse -> y_out sequence 0,0,0,1 with y_valid; done in cycle 6; sig=1.
REQ-033 WIDTH=1, op=XOR -> y 0,1,1,0; sig=0; op=XNOR -> y 1,0,0,1; sig=0.
REQ-034 WIDTH=2, op=NOT -> 16 y_valid cycles; y_out = ~a_out of the previous cycle; done in cycle 18; busy high cycles 1..17.
REQ-035 WIDTH=2, op=7 -> all y_out=0 and sig=0; start re-asserted mid-sweep -> no restart and no extra valid.
REQ-036 rst asserted in cycle 5 of a WIDTH=2 OR sweep -> next cycle IDLE with all outputs 0 and no done; a fresh start then completes normally.
REQ-037 Build without GATE_SWEEP_SIG_EN, repeat the AND sweep -> identical y_out/done timing, sig constantly 0.
